// File: rtl/score_display_mux_if.sv
// Bus between the score logic and the 4-digit 7-segment display driver.
// Score patterns are active-high segment masks (bit6=a .. bit0=g); the
// display side drives active-low cathodes, anodes and the decimal point.
interface score_display_mux_if;
  logic [6:0] score_l;
  logic [6:0] score_r;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (output score_l, output score_r, input seg, input an, input dp);
  modport slave  (input score_l, input score_r, output seg, output an, output dp);
endinterface

// File: rtl/score_display_mux.sv
// Scans two score digits onto a 4-digit common-anode display (outer digits
// only, inner two blank) and blinks a digit a few times whenever its score
// changes. Score inputs are asynchronous and are filtered through a
// three-flop synchroniser that only accepts values stable for two samples.
module score_display_mux #(
  parameter int REFRESH_DIV = 25000,
  parameter int FLASH_DIV   = 250,
  parameter int FLASH_COUNT = 3
) (
  input  logic              dclk,
  input  logic              clr_n,
  score_display_mux_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int PH_W  = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int REM_W = $clog2(FLASH_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(FLASH_DIV - 1);
  localparam logic [REM_W-1:0] REM_LOAD   = REM_W'(FLASH_COUNT);
  localparam logic [6:0]       DIGIT_ZERO = 7'b1111110;
  localparam logic [6:0]       SEG_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {IDLE, OFF, ON} flash_state_e;

  // Side index 1 = left score, 0 = right score (matches mask {l,r}).
  logic [1:0][6:0] raw;
  logic [1:0][6:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, cap_q, cap_d;
  logic [1:0]      chg;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             tick;

  flash_state_e     state_q, state_d;
  logic [1:0]       mask_q, mask_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [REM_W-1:0] rem_q, rem_d;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       blank_l, blank_r;

  assign raw = {bus.score_l, bus.score_r};

  // Synchroniser shift and capture of a value seen on two consecutive samples.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    s3_d  = s2_q;
    cap_d = cap_q;
    chg   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if ((s2_q[i] == s3_q[i]) && (s2_q[i] != cap_q[i])) begin
        cap_d[i] = s2_q[i];
        chg[i]   = 1'b1;
      end
    end
  end

  // Synchroniser and captured-score registers; reset shows a zero score.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      s1_q  <= {2{DIGIT_ZERO}};
      s2_q  <= {2{DIGIT_ZERO}};
      s3_q  <= {2{DIGIT_ZERO}};
      cap_q <= {2{DIGIT_ZERO}};
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      cap_q <= cap_d;
    end
  end

  // Scan divider and digit index; tick marks the last cycle of each digit slot.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = tick ? idx_q + 2'd1 : idx_q;
  end

  // Scan counter and digit index registers.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Flash sequencer: a score change always restarts the blink train, even
  // when it lands on the final ON expiry.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    if (|chg) begin
      state_d = OFF;
      mask_d  = mask_q | chg;
      phase_d = '0;
      rem_d   = REM_LOAD;
    end else begin
      case (state_q)
        OFF: begin
          if (tick) begin
            if (phase_q == PH_LAST) begin
              state_d = ON;
              phase_d = '0;
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end
        end
        ON: begin
          if (tick) begin
            if (phase_q == PH_LAST) begin
              phase_d = '0;
              if (rem_q <= REM_W'(1)) begin
                state_d = IDLE;
                mask_d  = 2'b00;
                rem_d   = '0;
              end else begin
                state_d = OFF;
                rem_d   = rem_q - REM_W'(1);
              end
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          mask_d  = 2'b00;
          phase_d = '0;
        end
      endcase
    end
  end

  // Flash sequencer state registers.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      mask_q  <= 2'b00;
      phase_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
    end
  end

  // Digit select: right score on an[0], left on an[3], inner digits blank.
  always_comb begin
    blank_l = (state_q == OFF) && mask_q[1];
    blank_r = (state_q == OFF) && mask_q[0];
    an_d    = 4'b1111;
    seg_d   = SEG_BLANK;
    case (idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = blank_r ? SEG_BLANK : ~cap_q[0];
      end
      2'd1: an_d = 4'b1101;
      2'd2: an_d = 4'b1011;
      default: begin
        an_d  = 4'b0111;
        seg_d = blank_l ? SEG_BLANK : ~cap_q[1];
      end
    endcase
  end

  // Registered display drive; reset turns every digit off immediately.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_score_display_mux.sv
// Bench for score_display_mux with a small refresh/flash configuration.
// Reference model: a digit slot is (cycle / RD) mod 4; a score is adopted
// once it has been sampled on two consecutive edges; a flash lasts
// 2*FD*FC scan ticks after its last restart, blanking during even
// FD-tick windows.
module tb_score_display_mux;
  localparam int RD = 4;
  localparam int FD = 2;
  localparam int FC = 2;

  logic dclk  = 1'b0;
  logic clr_n = 1'b0;

  score_display_mux_if bus ();

  score_display_mux #(
    .REFRESH_DIV(RD),
    .FLASH_DIV  (FD),
    .FLASH_COUNT(FC)
  ) dut (
    .dclk (dclk),
    .clr_n(clr_n),
    .bus  (bus.slave)
  );

  always #5 dclk = ~dclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_n;
  logic [6:0] hl[3];
  logic [6:0] hr[3];
  logic [6:0] m_cap_l, m_cap_r;
  bit         m_active;
  int         m_e;
  logic [1:0] m_mask;

  typedef struct {
    logic [6:0] l;
    logic [6:0] r;
    logic [6:0] el;
    logic [6:0] er;
  } vec_t;
  vec_t vecs[5];

  logic [6:0] digits[10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    for (int i = 0; i < 3; i++) begin
      hl[i] = 7'b1111110;
      hr[i] = 7'b1111110;
    end
    m_cap_l  = 7'b1111110;
    m_cap_r  = 7'b1111110;
    m_active = 0;
    m_e      = 0;
    m_mask   = 2'b00;
  endtask

  // One dclk edge: predict outputs, advance the model, compare.
  task automatic step();
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       cl, cr;
    bit         tick, fl_off;
    int         idx;
    idx    = (m_n / RD) % 4;
    fl_off = m_active && (((m_e / FD) % 2) == 0);
    case (idx)
      0: begin ean = 4'b1110; eseg = (fl_off && m_mask[0]) ? 7'h7F : ~m_cap_r; end
      1: begin ean = 4'b1101; eseg = 7'h7F; end
      2: begin ean = 4'b1011; eseg = 7'h7F; end
      default: begin ean = 4'b0111; eseg = (fl_off && m_mask[1]) ? 7'h7F : ~m_cap_l; end
    endcase
    tick = ((m_n % RD) == RD - 1);
    cl = (hl[1] == hl[2]) && (hl[1] != m_cap_l);
    cr = (hr[1] == hr[2]) && (hr[1] != m_cap_r);
    if (cl || cr) begin
      m_mask   = m_mask | {cl, cr};
      m_active = 1;
      m_e      = 0;
    end else if (m_active && tick) begin
      m_e++;
      if (m_e == 2 * FD * FC) begin
        m_active = 0;
        m_mask   = 2'b00;
      end
    end
    if (cl) m_cap_l = hl[1];
    if (cr) m_cap_r = hr[1];
    hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = bus.score_l;
    hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = bus.score_r;
    m_n++;
    @(posedge dclk);
    #1;
    chk("an", 32'(bus.an), 32'(ean));
    chk("seg", 32'(bus.seg), 32'(eseg));
  endtask

  task automatic frame_check(string tag, logic [6:0] el, logic [6:0] er);
    for (int i = 0; i < RD * 4; i++) begin
      step();
      if (bus.an == 4'b0111) chk({tag, "_left"}, 32'(bus.seg), 32'(el));
      else if (bus.an == 4'b1110) chk({tag, "_right"}, 32'(bus.seg), 32'(er));
    end
    chk({tag, "_dp"}, 32'(bus.dp), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge dclk);
    clr_n = 1'b0;
    #1;
    chk("rst_an_async", 32'(bus.an), 32'hF);
    chk("rst_seg_async", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'd1);
    bus.score_l = 7'b1111110;
    bus.score_r = 7'b1111110;
    repeat (2) @(posedge dclk);
    #1;
    chk("rst_an_hold", 32'(bus.an), 32'hF);
    chk("rst_seg_hold", 32'(bus.seg), 32'h7F);
    @(negedge dclk);
    clr_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [6:0] cur_r;
    int hold;
    digits = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    vecs[0] = '{l: 7'h7E, r: 7'h30, el: 7'h01, er: 7'h4F};
    vecs[1] = '{l: 7'h6D, r: 7'h79, el: 7'h12, er: 7'h06};
    vecs[2] = '{l: 7'h33, r: 7'h5B, el: 7'h4C, er: 7'h24};
    vecs[3] = '{l: 7'h7F, r: 7'h00, el: 7'h00, er: 7'h7F};
    vecs[4] = '{l: 7'h30, r: 7'h7E, el: 7'h4F, er: 7'h01};

    bus.score_l = 7'b1111110;
    bus.score_r = 7'b1111110;
    model_reset();
    do_reset();

    // First registered output after release selects the right digit.
    step();
    chk("first_an", 32'(bus.an), 32'hE);
    chk("first_seg", 32'(bus.seg), 32'h01);
    frame_check("idle_zero", 7'h01, 7'h01);
    repeat (20) step();

    // Steady-state table, each entry changes both sides together.
    for (int v = 0; v < 5; v++) begin
      bus.score_l = vecs[v].l;
      bus.score_r = vecs[v].r;
      repeat (80) step();
      frame_check($sformatf("vec%0d", v), vecs[v].el, vecs[v].er);
    end
    cur_r = 7'h7E;

    // One-cycle glitch on the left score is ignored.
    bus.score_l = 7'h7B;
    step();
    bus.score_l = 7'h30;
    repeat (60) step();
    frame_check("glitch", 7'h4F, 7'h01);

    // Right change, then left changes twice, the second during ON.
    bus.score_r = 7'h6D;
    repeat (6) step();
    bus.score_l = 7'h79;
    repeat (16) step();
    bus.score_l = 7'h5B;
    repeat (80) step();
    frame_check("restart", 7'h24, 7'h12);

    // Reset asserted while the right digit is blanked.
    bus.score_r = 7'h30;
    repeat (8) step();
    do_reset();
    step();
    chk("post_rst_an", 32'(bus.an), 32'hE);
    chk("post_rst_seg", 32'(bus.seg), 32'h01);
    repeat (40) step();

    // Randomised score changes with random hold lengths.
    cur_r = 7'h7E;
    for (int k = 0; k < 300; k++) begin
      bus.score_l = ($urandom_range(0, 2) == 0) ? digits[$urandom_range(0, 9)] : bus.score_l;
      cur_r = digits[$urandom_range(0, 9)];
      if ($urandom_range(0, 1) == 0) bus.score_r = cur_r;
      hold = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 40);
      repeat (hold) step();
    end
    repeat (60) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_display_mux.md
SCORE_DISPLAY_MUX -- requirements
Module: score_display_mux

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 25000, giving the dclk cycles per digit scan tick (1 ms at 25 MHz).
REQ-002 The module SHALL have parameter FLASH_DIV, default 250, giving the scan ticks per flash half-period.
REQ-003 The module SHALL have parameter FLASH_COUNT, default 3, giving the number of off/on blink pairs per score event.
REQ-004 The module SHALL have port dclk, input, 1 bit: the single clock; all flops use its rising edge.
REQ-005 The module SHALL have port clr_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port score_l, input, 7 bits: left-score segment pattern, active high, bit6=a .. bit0=g; asynchronous to dclk.
REQ-007 The module SHALL have port score_r, input, 7 bits: right-score segment pattern, same encoding, asynchronous to dclk.
REQ-008 The module SHALL have port seg, output, 7 bits: cathodes, active low, seg[6]=a .. seg[0]=g.
REQ-009 The module SHALL have port an, output, 4 bits: digit anodes, active low, an[3]=leftmost.
REQ-010 The module SHALL have port dp, output, 1 bit: decimal point, active low, held 1.

Function
REQ-011 Each score input SHALL pass through three flops s1->s2->s3, and the captured value cap SHALL load s2 when s2==s3 and s2!=cap.
REQ-012 Resulting capture latency SHALL be 3 dclk edges after the first edge that samples a new value; a value held for fewer than 2 sampled edges SHALL never be captured.
REQ-013 A cap load SHALL assert a one-cycle internal change flag for that side; both sides loading in the same cycle SHALL assert both flags.
REQ-014 The scan counter SHALL count 0..REFRESH_DIV-1 and wrap, with the scan tick true in the cycle the count equals REFRESH_DIV-1.
REQ-015 The 2-bit digit index SHALL increment on each scan tick, wrapping 3->0.
REQ-016 Index 0 SHALL drive an=1110 with cap_r; index 1 SHALL drive an=1101 blank; index 2 SHALL drive an=1011 blank; index 3 SHALL drive an=0111 with cap_l.
REQ-017 seg SHALL equal the bitwise inverse of the selected pattern, and blank SHALL mean seg=1111111.
REQ-018 seg and an SHALL be registered, one dclk after the index/cap/flash state that selects them.
REQ-019 The flash FSM SHALL have states IDLE, OFF, ON, plus a 2-bit mask {l,r}, a phase counter (scan ticks), and a remaining counter.
REQ-020 Any change flag, in any state, SHALL OR the side(s) into mask, go to OFF, clear phase, and load remaining=FLASH_COUNT (restart).
REQ-021 In OFF, masked digits SHALL be blank; after FLASH_DIV scan ticks the FSM SHALL go to ON with phase cleared.
REQ-022 In ON, masked digits SHALL display normally; after FLASH_DIV scan ticks remaining SHALL decrement, and the FSM SHALL go to IDLE with mask=00 if remaining becomes 0, else to OFF.
REQ-023 In IDLE, mask SHALL be 00 and no digit SHALL be blanked by the FSM.
REQ-024 A change flag coinciding with the final ON expiry SHALL take priority (restart, not IDLE).
REQ-025 Counters SHALL never exceed their terminal values, with no underflow of remaining.

Reset
REQ-026 clr_n=0 SHALL immediately force an=1111, seg=1111111, dp=1, and SHALL clear the scan counter, index, phase and remaining to 0, with FSM=IDLE and mask=00.
REQ-027 clr_n=0 SHALL load s1/s2/s3/cap of both sides with 1111110 (digit 0), so the post-reset zero score does not flash.
REQ-028 Reset asserted mid-flash SHALL abort the flash, and on release display SHALL resume from index 0 with the FSM in IDLE.
REQ-029 The first registered output after reset release SHALL be an=1110 with seg=~cap_r.

Verification (REFRESH_DIV=4, FLASH_DIV=2, FLASH_COUNT=2)
REQ-030 Reset release, inputs 1111110 -> an cycles 1110,1101,1011,0111 every 4 dclk; seg=0000001 on an[0]/an[3], 1111111 otherwise; no blanking.
REQ-031 score_r 1111110->0110000 held -> cap_r updates 3 edges later; right digit blank 8 dclk, shown 8, blank 8, shown 8, then steady seg=1001111.
REQ-032 score_l 1-cycle glitch to 1111111 -> no capture, no flash, seg for an[3] unchanged.
REQ-033 score_l and score_r change on the same edge -> mask=11, both digits blink together for 2 pairs.
REQ-034 Second score_l change during ON of the first flash -> FSM restarts OFF, remaining=2, mask retains r if already set.
REQ-035 clr_n pulsed low during OFF -> outputs 1111/1111111 asynchronously; after release, FSM=IDLE and the display is not blanked.
